// File: rtl/ava_alu_pkg.sv
// Shared opcodes, register offsets and byte-lane merge helper for the ava_alu peripheral.
// Build option: ALU_SHIFT_EN enables opcodes 6 (SLL) and 7 (SRL).
package ava_alu_pkg;

   typedef logic [3:0] op_t;
   typedef logic [1:0] reg_addr_t;

   localparam op_t OP_ADD = 4'd1;
   localparam op_t OP_SUB = 4'd2;
   localparam op_t OP_AND = 4'd3;
   localparam op_t OP_OR  = 4'd4;
   localparam op_t OP_XOR = 4'd5;
   localparam op_t OP_SLL = 4'd6;
   localparam op_t OP_SRL = 4'd7;

   localparam reg_addr_t REG_A    = 2'd0;
   localparam reg_addr_t REG_B    = 2'd1;
   localparam reg_addr_t REG_CTRL = 2'd2;
   localparam reg_addr_t REG_RES  = 2'd3;

   // Replace only the byte lanes whose enable bit is set.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/ava_alu_if.sv
// Avalon-MM slave bus bundle for the ava_alu peripheral.
interface ava_alu_if #(parameter int DATA_W = 32);

   logic                  ava_chipselect;
   logic [1:0]            ava_address;
   logic                  ava_read;
   logic                  ava_write;
   logic [DATA_W-1:0]     ava_readdata;
   logic [DATA_W-1:0]     ava_writedata;
   logic [DATA_W/8-1:0]   ava_byteenable;
   logic                  ava_waitrequest;

   modport slave (
      input  ava_chipselect, ava_address, ava_read, ava_write,
             ava_writedata, ava_byteenable,
      output ava_readdata, ava_waitrequest
   );

   modport master (
      output ava_chipselect, ava_address, ava_read, ava_write,
             ava_writedata, ava_byteenable,
      input  ava_readdata, ava_waitrequest
   );

endinterface

// File: rtl/ava_alu_core.sv
// Combinational ALU datapath: (op, a, b) -> y. Undefined opcodes yield zero.
// Build option: ALU_SHIFT_EN adds SLL/SRL on opcodes 6/7.
module ava_alu_core
   import ava_alu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  op_t               op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] y_o
);

   always_comb begin
      y_o = '0;
      case (op_i)
         OP_ADD: y_o = a_i + b_i;
         OP_SUB: y_o = a_i - b_i;
         OP_AND: y_o = a_i & b_i;
         OP_OR:  y_o = a_i | b_i;
         OP_XOR: y_o = a_i ^ b_i;
`ifdef ALU_SHIFT_EN
         OP_SLL: y_o = a_i << b_i[4:0];
         OP_SRL: y_o = a_i >> b_i[4:0];
`else
         OP_SLL: y_o = '0;
         OP_SRL: y_o = '0;
`endif
         default: y_o = '0;
      endcase
   end

endmodule

// File: rtl/ava_alu.sv
// Avalon-MM ALU peripheral: operand/control/result registers behind a one-wait-state slave.
// Build option: ALU_SHIFT_EN enables shift opcodes in ava_alu_core.
//
// state    | meaning
// ST_WAIT  | no ack yet; a pending request sees waitrequest=1
// ST_ACK   | request acknowledged this cycle; write commits / readdata loads at edge
module ava_alu
   import ava_alu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic        clk,
   input  logic        reset,
   ava_alu_if.slave    bus
);

   localparam logic [0:0] ST_WAIT = 1'b0;
   localparam logic [0:0] ST_ACK  = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   op_t               ctrl_q, ctrl_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              start_q, start_d;

   logic              req;
   logic              commit;
   logic [DATA_W-1:0] alu_y;

   assign req    = bus.ava_chipselect & (bus.ava_read | bus.ava_write);
   assign commit = req & (state_q == ST_ACK);

   assign bus.ava_waitrequest = req & (state_q == ST_WAIT);
   assign bus.ava_readdata    = rdata_q;

   ava_alu_core #(.DATA_W(DATA_W)) u_core (
      .op_i (ctrl_q),
      .a_i  (a_q),
      .b_i  (b_q),
      .y_o  (alu_y)
   );

   always_comb begin
      state_d = (req && state_q == ST_WAIT) ? ST_ACK : ST_WAIT;
   end

   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      ctrl_d  = ctrl_q;
      res_d   = res_q;
      rdata_d = rdata_q;
      start_d = 1'b0;

      // start_q lags the CTRL commit by one edge, so the ALU sees committed operands
      if (start_q) res_d = alu_y;

      if (commit && bus.ava_write) begin
         case (bus.ava_address)
            REG_A: a_d = merge_bytes(a_q, bus.ava_writedata, bus.ava_byteenable);
            REG_B: b_d = merge_bytes(b_q, bus.ava_writedata, bus.ava_byteenable);
            REG_CTRL: begin
               if (bus.ava_byteenable[0]) begin
                  ctrl_d  = bus.ava_writedata[3:0];
                  start_d = 1'b1;
               end
            end
            default: ;
         endcase
      end

      if (commit && bus.ava_read) begin
         case (bus.ava_address)
            REG_A:    rdata_d = a_q;
            REG_B:    rdata_d = b_q;
            REG_CTRL: rdata_d = {{(DATA_W-4){1'b0}}, ctrl_q};
            default:  rdata_d = res_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_WAIT;
         a_q     <= '0;
         b_q     <= '0;
         ctrl_q  <= '0;
         res_q   <= '0;
         rdata_q <= '0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ctrl_q  <= ctrl_d;
         res_q   <= res_d;
         rdata_q <= rdata_d;
         start_q <= start_d;
      end
   end

endmodule

// File: tb/tb_ava_alu.sv
// Directed self-checking bench for ava_alu using simple Avalon master tasks.
// Build option: ALU_SHIFT_EN selects the shift-opcode expectations.
module tb_ava_alu;
   import ava_alu_pkg::*;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   ava_alu_if #(.DATA_W(32)) bus ();

   ava_alu #(.DATA_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic bus_idle();
      bus.ava_chipselect = 1'b0;
      bus.ava_read       = 1'b0;
      bus.ava_write      = 1'b0;
      bus.ava_address    = 2'd0;
      bus.ava_writedata  = '0;
      bus.ava_byteenable = 4'h0;
   endtask

   // Called just after a rising edge; returns just after the edge that completes the transfer.
   task automatic ava_wr1(input logic [1:0] addr, input logic [31:0] data, input logic [3:0] be);
      int waits;
      waits = 0;
      bus.ava_chipselect = 1'b1;
      bus.ava_write      = 1'b1;
      bus.ava_address    = addr;
      bus.ava_writedata  = data;
      bus.ava_byteenable = be;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (!bus.ava_waitrequest) break;
         waits++;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      bus_idle();
      chk("wr_waits", 32'(waits), 32'd1);
   endtask

   task automatic ava_rd1(input logic [1:0] addr, output logic [31:0] data);
      int waits;
      waits = 0;
      bus.ava_chipselect = 1'b1;
      bus.ava_read       = 1'b1;
      bus.ava_address    = addr;
      bus.ava_byteenable = 4'h0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (!bus.ava_waitrequest) break;
         waits++;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      data = bus.ava_readdata;
      bus_idle();
      chk("rd_waits", 32'(waits), 32'd1);
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      ava_rd1(addr, d);
      chk(tag, d, exp);
   endtask

   logic [3:0]  ops  [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
   logic [31:0] exps [5] = '{32'h02468ACF, 32'hFFFFFFFF, 32'h01234560,
                             32'h0123456F, 32'h0000000F};

   initial begin
      n_tests = 0;
      n_fail  = 0;
      bus_idle();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      @(negedge clk);
      chk("idle_wait", {31'b0, bus.ava_waitrequest}, 32'd0);
      chk("rst_rdata", bus.ava_readdata, 32'd0);
      @(posedge clk); #1;
      rd_chk("rst_a",    REG_A,    32'd0);
      rd_chk("rst_b",    REG_B,    32'd0);
      rd_chk("rst_ctrl", REG_CTRL, 32'd0);
      rd_chk("rst_res",  REG_RES,  32'd0);

      ava_wr1(REG_A, 32'hFFFFFFFF, 4'b0011);
      rd_chk("partial_a", REG_A, 32'h0000FFFF);

      ava_wr1(REG_A, 32'h01234567, 4'hF);
      ava_wr1(REG_B, 32'h01234568, 4'hF);
      rd_chk("a_full", REG_A, 32'h01234567);
      for (int i = 0; i < 5; i++) begin
         ava_wr1(REG_CTRL, {28'b0, ops[i]}, 4'hF);
         rd_chk($sformatf("op%0d", ops[i]), REG_RES, exps[i]);
      end

      ava_wr1(REG_RES, 32'h0000DEAD, 4'hF);
      rd_chk("res_ro", REG_RES, 32'h0000000F);

      ava_wr1(REG_CTRL, 32'hFFFFFFF5, 4'hF);
      rd_chk("ctrl_mask", REG_CTRL, 32'h00000005);

      // Operand change alone must not recompute the result
      ava_wr1(REG_A, 32'h00000000, 4'hF);
      rd_chk("no_recalc", REG_RES, 32'h0000000F);

      ava_wr1(REG_CTRL, 32'h0000000E, 4'hF);
      rd_chk("op_undef", REG_RES, 32'h00000000);

      // CTRL write without byte lane 0 neither stores nor starts
      ava_wr1(REG_A, 32'h00000003, 4'hF);
      ava_wr1(REG_CTRL, 32'h00000001, 4'b1110);
      rd_chk("ctrl_be0_ctrl", REG_CTRL, 32'h0000000E);
      rd_chk("ctrl_be0_res",  REG_RES,  32'h00000000);

      bus.ava_chipselect = 1'b0;
      bus.ava_write      = 1'b1;
      bus.ava_read       = 1'b1;
      bus.ava_address    = REG_A;
      bus.ava_writedata  = 32'h00000BAD;
      bus.ava_byteenable = 4'hF;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk("cs0_wait", {31'b0, bus.ava_waitrequest}, 32'd0);
      end
      @(posedge clk); #1;
      bus_idle();
      rd_chk("cs0_a", REG_A, 32'h00000003);

      ava_wr1(REG_A, 32'h00000001, 4'hF);
      ava_wr1(REG_B, 32'h00000004, 4'hF);
      ava_wr1(REG_CTRL, 32'h00000006, 4'hF);
`ifdef ALU_SHIFT_EN
      rd_chk("op6", REG_RES, 32'h00000010);
`else
      rd_chk("op6", REG_RES, 32'h00000000);
`endif
      ava_wr1(REG_A, 32'h80000000, 4'hF);
      ava_wr1(REG_B, 32'h0000001F, 4'hF);
      ava_wr1(REG_CTRL, 32'h00000007, 4'hF);
`ifdef ALU_SHIFT_EN
      rd_chk("op7", REG_RES, 32'h00000001);
`else
      rd_chk("op7", REG_RES, 32'h00000000);
`endif

      // Reset lands on the wait state of a held write; afterwards the request restarts
      bus.ava_chipselect = 1'b1;
      bus.ava_write      = 1'b1;
      bus.ava_address    = REG_A;
      bus.ava_writedata  = 32'hCAFEBABE;
      bus.ava_byteenable = 4'hF;
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_wait", {31'b0, bus.ava_waitrequest}, 32'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst_restart_wait", {31'b0, bus.ava_waitrequest}, 32'd1);
      bus_idle();
      @(posedge clk); #1;
      rd_chk("post_rst_a",    REG_A,    32'd0);
      rd_chk("post_rst_b",    REG_B,    32'd0);
      rd_chk("post_rst_ctrl", REG_CTRL, 32'd0);
      rd_chk("post_rst_res",  REG_RES,  32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
